// File: rtl/proc_core_param_pkg.sv
// Shared types for the parametrised multicycle core:
// opcodes, step states, bus sources and field-width helpers.
package proc_pkg;

  localparam int OPW = 3;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVNZ = 3'b101,
    OP_XOR  = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  typedef enum logic [2:0] {
    BS_ZERO,
    BS_DIN,
    BS_RX,
    BS_RY,
    BS_G
  } bsel_e;

  function automatic int rw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/proc_core_param_if.sv
// Run/Done handshake and observation bundle of the core.
// The master drives Run/DIN; the core is the slave.
interface proc_core_param_if #(
  parameter int DATA_W = 16
);

  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic              Done;
  logic [DATA_W-1:0] BusWires;
  logic [DATA_W-1:0] IR_out;
  logic [1:0]        Tstep_state;
  logic              Z_out;

  modport master (
    output Run,
    output DIN,
    input  Done,
    input  BusWires,
    input  IR_out,
    input  Tstep_state,
    input  Z_out
  );

  modport slave (
    input  Run,
    input  DIN,
    output Done,
    output BusWires,
    output IR_out,
    output Tstep_state,
    output Z_out
  );

endinterface

// File: rtl/proc_core_param_alu.sv
// Combinational ALU of the core: add, sub, and, xor.
// Non-ALU opcodes yield zero; the caller never latches them.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/proc_core_param.sv
// Parametrised multicycle core: register file, A/G, IR,
// zero flag and T0..T3 step FSM around one shared bus.
module proc_core_param
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input logic              PClock,
  input logic              Resetn,
  proc_core_param_if.slave cpu
);

  localparam int RW = rw(NREGS);

  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("NREGS must be a power of two >= 2");
  end
  if (DATA_W < OPW + 2 * RW) begin : g_bad_width
    $error("DATA_W too narrow for opcode and register fields");
  end

  tstep_e            tstep_q, tstep_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic              z_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  op_e               op;
  logic [RW-1:0]     rx;
  logic [RW-1:0]     ry;
  logic              is_mv, is_mvi, is_mvnz;
  logic              is_nop, is_alu;

  bsel_e             bsel;
  logic              ir_we, rx_we, a_we, g_we;
  logic              done;
  logic [DATA_W-1:0] bus_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  assign op = op_e'(ir_q[DATA_W-1 -: OPW]);
  assign rx = ir_q[DATA_W-OPW-1 -: RW];
  assign ry = ir_q[DATA_W-OPW-RW-1 -: RW];

  always_comb begin
    is_mv   = (op == OP_MV);
    is_mvi  = (op == OP_MVI);
    is_mvnz = (op == OP_MVNZ);
    is_nop  = (op == OP_NOP);
    is_alu  = (op == OP_ADD) || (op == OP_SUB) ||
              (op == OP_AND) || (op == OP_XOR);
  end

  always_comb begin
    tstep_d = tstep_q;
    bsel    = BS_ZERO;
    ir_we   = 1'b0;
    rx_we   = 1'b0;
    a_we    = 1'b0;
    g_we    = 1'b0;
    done    = 1'b0;
    case (tstep_q)
      T0: begin
        if (cpu.Run) begin
          ir_we   = 1'b1;
          tstep_d = T1;
        end
      end
      T1: begin
        unique case (1'b1)
          is_mv: begin
            bsel    = BS_RY;
            rx_we   = 1'b1;
            done    = 1'b1;
            tstep_d = T0;
          end
          is_mvi: begin
            bsel    = BS_DIN;
            rx_we   = 1'b1;
            done    = 1'b1;
            tstep_d = T0;
          end
          is_mvnz: begin
            bsel    = BS_RY;
            rx_we   = ~z_q;
            done    = 1'b1;
            tstep_d = T0;
          end
          is_nop: begin
            done    = 1'b1;
            tstep_d = T0;
          end
          is_alu: begin
            bsel    = BS_RX;
            a_we    = 1'b1;
            tstep_d = T2;
          end
        endcase
      end
      T2: begin
        bsel    = BS_RY;
        g_we    = 1'b1;
        tstep_d = T3;
      end
      T3: begin
        bsel    = BS_G;
        rx_we   = 1'b1;
        done    = 1'b1;
        tstep_d = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  always_comb begin
    bus_w = '0;
    case (bsel)
      BS_DIN:  bus_w = cpu.DIN;
      BS_RX:   bus_w = regs_q[rx];
      BS_RY:   bus_w = regs_q[ry];
      BS_G:    bus_w = g_q;
      default: bus_w = '0;
    endcase
  end

  proc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op_i    (op),
    .a_i     (a_q),
    .b_i     (bus_w),
    .result_o(alu_res),
    .zero_o  (alu_zero)
  );

  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn) begin
      tstep_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b1;
    end else begin
      tstep_q <= tstep_d;
      if (ir_we) ir_q <= cpu.DIN;
      if (a_we)  a_q  <= bus_w;
      if (g_we) begin
        g_q <= alu_res;
        z_q <= alu_zero;
      end
    end
  end

  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rx_we) begin
      regs_q[rx] <= bus_w;
    end
  end

  assign cpu.Done        = done;
  assign cpu.BusWires    = bus_w;
  assign cpu.IR_out      = ir_q;
  assign cpu.Tstep_state = tstep_q;
  assign cpu.Z_out       = z_q;

endmodule

// File: tb/tb_proc_core_param.sv
// Directed bench for proc_core_param: a 16-bit/8-reg core
// and a 9-bit/4-reg core, registers observed via mv Rk,Rk.
`timescale 1ns/1ps
module tb_proc_core_param;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rstn_a = 1'b1;
  logic rstn_b = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  proc_core_param_if #(.DATA_W(16)) ifa ();
  proc_core_param_if #(.DATA_W(9))  ifb ();

  proc_core_param #(.DATA_W(16), .NREGS(8)) u_a (
    .PClock(clk),
    .Resetn(rstn_a),
    .cpu   (ifa)
  );

  proc_core_param #(.DATA_W(9), .NREGS(4)) u_b (
    .PClock(clk),
    .Resetn(rstn_b),
    .cpu   (ifb)
  );

  function automatic logic [15:0] ea(
    input logic [2:0] op, input logic [2:0] x,
    input logic [2:0] y);
    return {op, x, y, 7'b0};
  endfunction

  function automatic logic [8:0] eb(
    input logic [2:0] op, input logic [1:0] x,
    input logic [1:0] y);
    return {op, x, y, 2'b0};
  endfunction

  task automatic a_go(input logic [15:0] ins,
                      input logic [15:0] imm);
    ifa.Run = 1'b1;
    ifa.DIN = ins;
    @(negedge clk);
    ifa.Run = 1'b0;
    ifa.DIN = imm;
    #1;
  endtask

  task automatic a_run(input logic [15:0] ins,
                       input logic [15:0] imm);
    a_go(ins, imm);
    for (int i = 0; i < 4; i++) begin
      if (ifa.Tstep_state == 2'd0) break;
      @(negedge clk);
    end
    ifa.DIN = '0;
    n_chk++;
    if (ifa.Tstep_state !== 2'd0) begin
      n_fail++;
      $display("FAIL a_run_timeout: step %0d want 0",
               ifa.Tstep_state);
    end
  endtask

  task automatic a_read(input logic [2:0] k,
                        output logic [15:0] v);
    a_go(ea(OP_MV, k, k), 16'h0);
    v = ifa.BusWires;
    @(negedge clk);
  endtask

  task automatic b_go(input logic [8:0] ins,
                      input logic [8:0] imm);
    ifb.Run = 1'b1;
    ifb.DIN = ins;
    @(negedge clk);
    ifb.Run = 1'b0;
    ifb.DIN = imm;
    #1;
  endtask

  task automatic b_run(input logic [8:0] ins,
                       input logic [8:0] imm);
    b_go(ins, imm);
    for (int i = 0; i < 4; i++) begin
      if (ifb.Tstep_state == 2'd0) break;
      @(negedge clk);
    end
    ifb.DIN = '0;
    n_chk++;
    if (ifb.Tstep_state !== 2'd0) begin
      n_fail++;
      $display("FAIL b_run_timeout: step %0d want 0",
               ifb.Tstep_state);
    end
  endtask

  task automatic b_read(input logic [1:0] k,
                        output logic [8:0] v);
    b_go(eb(OP_MV, k, k), 9'h0);
    v = ifb.BusWires;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    ifa.Run = 1'b0;
    ifa.DIN = '0;
    ifb.Run = 1'b0;
    ifb.DIN = '0;
    #2;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.Z_out,
         ifa.BusWires, ifa.IR_out} !==
        {2'd0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_a: T%0d D%b Z%b bus %h ir %h",
               ifa.Tstep_state, ifa.Done, ifa.Z_out,
               ifa.BusWires, ifa.IR_out);
    end
    n_chk++;
    if ({ifb.Tstep_state, ifb.Done, ifb.Z_out,
         ifb.BusWires, ifb.IR_out} !==
        {2'd0, 1'b0, 1'b1, 9'h0, 9'h0}) begin
      n_fail++;
      $display("FAIL reset_b: T%0d D%b Z%b bus %h ir %h",
               ifb.Tstep_state, ifb.Done, ifb.Z_out,
               ifb.BusWires, ifb.IR_out);
    end
    @(negedge clk);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_read(3'(i), v);
      n_chk++;
      if (v !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_R%0d: got %h want 0000", i, v);
      end
    end
  endtask

  task automatic test_mvi();
    logic [15:0] v;
    a_go(ea(OP_MVI, 3'd0, 3'd0), 16'h0005);
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd1, 1'b1, 16'h0005}) begin
      n_fail++;
      $display("FAIL mvi_t1: T%0d D%b bus %h want T1 D1 0005",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.Z_out} !==
        {2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mvi_t0: T%0d D%b Z%b want T0 D0 Z1",
               ifa.Tstep_state, ifa.Done, ifa.Z_out);
    end
    a_read(3'd0, v);
    n_chk++;
    if (v !== 16'h0005) begin
      n_fail++;
      $display("FAIL mvi_R0: got %h want 0005", v);
    end
  endtask

  task automatic test_add();
    logic [15:0] v;
    a_run(ea(OP_MVI, 3'd1, 3'd0), 16'h0003);
    a_go(ea(OP_ADD, 3'd0, 3'd1), 16'h0);
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd1, 1'b0, 16'h0005}) begin
      n_fail++;
      $display("FAIL add_t1: T%0d D%b bus %h want T1 D0 0005",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd2, 1'b0, 16'h0003}) begin
      n_fail++;
      $display("FAIL add_t2: T%0d D%b bus %h want T2 D0 0003",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd3, 1'b1, 16'h0008}) begin
      n_fail++;
      $display("FAIL add_t3: T%0d D%b bus %h want T3 D1 0008",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.Z_out} !==
        {2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_t0: T%0d D%b Z%b want T0 D0 Z0",
               ifa.Tstep_state, ifa.Done, ifa.Z_out);
    end
    a_read(3'd0, v);
    n_chk++;
    if (v !== 16'h0008) begin
      n_fail++;
      $display("FAIL add_R0: got %h want 0008", v);
    end
  endtask

  task automatic test_sub();
    logic [15:0] v;
    a_run(ea(OP_MVI, 3'd2, 3'd0), 16'h0000);
    a_run(ea(OP_MVI, 3'd3, 3'd0), 16'h0001);
    a_go(ea(OP_SUB, 3'd2, 3'd3), 16'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd3, 1'b1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL sub_wrap_t3: T%0d D%b bus %h want T3 D1 ffff",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ifa.Z_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_wrap_z: got %b want 0", ifa.Z_out);
    end
    a_read(3'd2, v);
    n_chk++;
    if (v !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sub_wrap_R2: got %h want ffff", v);
    end
    a_go(ea(OP_SUB, 3'd2, 3'd2), 16'h0);
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.BusWires} !== {2'd2, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL sub_self_t2: T%0d bus %h want T2 ffff",
               ifa.Tstep_state, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd3, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL sub_self_t3: T%0d D%b bus %h want T3 D1 0000",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ifa.Z_out !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_self_z: got %b want 1", ifa.Z_out);
    end
    a_read(3'd2, v);
    n_chk++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL sub_self_R2: got %h want 0000", v);
    end
  endtask

  task automatic test_mvnz();
    logic [15:0] v;
    a_run(ea(OP_MVI, 3'd4, 3'd0), 16'h1234);
    a_go(ea(OP_MVNZ, 3'd4, 3'd0), 16'h0);
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd1, 1'b1, 16'h0008}) begin
      n_fail++;
      $display("FAIL mvnz_z1_t1: T%0d D%b bus %h want T1 D1 0008",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    a_read(3'd4, v);
    n_chk++;
    if (v !== 16'h1234) begin
      n_fail++;
      $display("FAIL mvnz_z1_R4: got %h want 1234", v);
    end
    a_run(ea(OP_XOR, 3'd7, 3'd0), 16'h0);
    n_chk++;
    if (ifa.Z_out !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_z: got %b want 0", ifa.Z_out);
    end
    a_read(3'd7, v);
    n_chk++;
    if (v !== 16'h0008) begin
      n_fail++;
      $display("FAIL xor_R7: got %h want 0008", v);
    end
    a_go(ea(OP_MVNZ, 3'd4, 3'd0), 16'h0);
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Z_out} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mvnz_z0_t0: T%0d Z%b want T0 Z0",
               ifa.Tstep_state, ifa.Z_out);
    end
    a_read(3'd4, v);
    n_chk++;
    if (v !== 16'h0008) begin
      n_fail++;
      $display("FAIL mvnz_z0_R4: got %h want 0008", v);
    end
  endtask

  task automatic test_run_ignored();
    logic [15:0] v;
    logic [15:0] ins;
    a_run(ea(OP_MVI, 3'd1, 3'd0), 16'h0FF0);
    a_run(ea(OP_MVI, 3'd6, 3'd0), 16'h3C3C);
    ins = ea(OP_AND, 3'd1, 3'd6);
    a_go(ins, 16'h0);
    @(negedge clk);
    ifa.Run = 1'b1;
    ifa.DIN = ea(OP_MVI, 3'd0, 3'd0);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.IR_out} !== {2'd2, ins}) begin
      n_fail++;
      $display("FAIL run_ign_t2: T%0d ir %h want T2 %h",
               ifa.Tstep_state, ifa.IR_out, ins);
    end
    @(negedge clk);
    ifa.Run = 1'b0;
    ifa.DIN = '0;
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires, ifa.IR_out} !==
        {2'd3, 1'b1, 16'h0C30, ins}) begin
      n_fail++;
      $display("FAIL run_ign_t3: T%0d D%b bus %h ir %h",
               ifa.Tstep_state, ifa.Done, ifa.BusWires,
               ifa.IR_out);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.IR_out} !==
        {2'd0, 1'b0, ins}) begin
      n_fail++;
      $display("FAIL run_ign_t0: T%0d D%b ir %h want T0 D0 %h",
               ifa.Tstep_state, ifa.Done, ifa.IR_out, ins);
    end
    a_read(3'd1, v);
    n_chk++;
    if (v !== 16'h0C30) begin
      n_fail++;
      $display("FAIL and_R1: got %h want 0c30", v);
    end
    a_read(3'd0, v);
    n_chk++;
    if (v !== 16'h0008) begin
      n_fail++;
      $display("FAIL run_ign_R0: got %h want 0008", v);
    end
  endtask

  task automatic test_back_to_back();
    ifa.Run = 1'b1;
    ifa.DIN = ea(OP_NOP, 3'd0, 3'd0);
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.BusWires} !==
        {2'd1, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL b2b_first: T%0d D%b bus %h want T1 D1 0000",
               ifa.Tstep_state, ifa.Done, ifa.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_gap: T%0d D%b want T0 D0",
               ifa.Tstep_state, ifa.Done);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.IR_out} !==
        {2'd1, 1'b1, 16'hE000}) begin
      n_fail++;
      $display("FAIL b2b_second: T%0d D%b ir %h want T1 D1 e000",
               ifa.Tstep_state, ifa.Done, ifa.IR_out);
    end
    ifa.Run = 1'b0;
    ifa.DIN = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    a_run(ea(OP_MVI, 3'd6, 3'd0), 16'h0003);
    a_go(ea(OP_ADD, 3'd5, 3'd6), 16'h0);
    @(negedge clk);
    #1;
    n_chk++;
    if (ifa.Tstep_state !== 2'd2) begin
      n_fail++;
      $display("FAIL rmid_t2: step %0d want 2", ifa.Tstep_state);
    end
    rstn_a = 1'b0;
    #1;
    n_chk++;
    if ({ifa.Tstep_state, ifa.Done, ifa.Z_out,
         ifa.BusWires, ifa.IR_out} !==
        {2'd0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL rmid_async: T%0d D%b Z%b bus %h ir %h",
               ifa.Tstep_state, ifa.Done, ifa.Z_out,
               ifa.BusWires, ifa.IR_out);
    end
    @(negedge clk);
    rstn_a = 1'b1;
    a_read(3'd5, v);
    n_chk++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmid_R5: got %h want 0000", v);
    end
    a_read(3'd6, v);
    n_chk++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmid_R6: got %h want 0000", v);
    end
  endtask

  task automatic test_cfg2();
    logic [8:0] v;
    b_run(eb(OP_MVI, 2'd0, 2'd0), 9'h1FF);
    b_run(eb(OP_MVI, 2'd1, 2'd0), 9'h001);
    b_run(eb(OP_MVI, 2'd2, 2'd0), 9'h001);
    b_run(eb(OP_ADD, 2'd2, 2'd2), 9'h0);
    n_chk++;
    if (ifb.Z_out !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg2_pre_z: got %b want 0", ifb.Z_out);
    end
    b_read(2'd2, v);
    n_chk++;
    if (v !== 9'h002) begin
      n_fail++;
      $display("FAIL cfg2_R2: got %h want 002", v);
    end
    b_go(eb(OP_ADD, 2'd0, 2'd1), 9'h0);
    n_chk++;
    if ({ifb.Tstep_state, ifb.Done, ifb.BusWires} !==
        {2'd1, 1'b0, 9'h1FF}) begin
      n_fail++;
      $display("FAIL cfg2_t1: T%0d D%b bus %h want T1 D0 1ff",
               ifb.Tstep_state, ifb.Done, ifb.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifb.Tstep_state, ifb.Done, ifb.BusWires} !==
        {2'd2, 1'b0, 9'h001}) begin
      n_fail++;
      $display("FAIL cfg2_t2: T%0d D%b bus %h want T2 D0 001",
               ifb.Tstep_state, ifb.Done, ifb.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifb.Tstep_state, ifb.Done, ifb.BusWires} !==
        {2'd3, 1'b1, 9'h000}) begin
      n_fail++;
      $display("FAIL cfg2_t3: T%0d D%b bus %h want T3 D1 000",
               ifb.Tstep_state, ifb.Done, ifb.BusWires);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifb.Tstep_state, ifb.Done, ifb.Z_out} !==
        {2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL cfg2_t0: T%0d D%b Z%b want T0 D0 Z1",
               ifb.Tstep_state, ifb.Done, ifb.Z_out);
    end
    b_read(2'd0, v);
    n_chk++;
    if (v !== 9'h000) begin
      n_fail++;
      $display("FAIL cfg2_R0: got %h want 000", v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mvi();
    test_add();
    test_sub();
    test_mvnz();
    test_run_ignored();
    test_back_to_back();
    test_reset_mid();
    test_cfg2();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_core_param.md
# proc_core_param

Parametrised successor to the 9-bit multicycle simple processor. It is a register-file datapath with a shared bus, A/G accumulator registers, an IR and a T0–T3 step counter. Data width and register count are generics, and the instruction set gains `sub`, `and`, `xor` and a conditional `mvnz` driven by a zero flag. Instructions arrive on DIN under the existing Run/Done handshake, so the block drops into `top_processor` in place of the fixed core, with the ROM feeding DIN.

## Interface
- `DATA_W`, default 16: datapath, bus, IR and DIN width. Must be ≥ 3+2·RW.
- `NREGS`, default 8: number of general registers R0..R(NREGS-1). Must be a power of two, ≥ 2.
- `PClock` in, 1 bit: processor clock. All state updates on the rising edge.
- `Resetn` in, 1 bit: asynchronous, active-low reset.
- `Run` in, 1 bit: start request, sampled in T0 only.
- `DIN` in, DATA_W bits: instruction word in T0; immediate word in T1 of `mvi`.
- `Done` out, 1 bit: combinational, high in the final step of each instruction.
- `BusWires` out, DATA_W bits: shared bus value.
- `IR_out` out, DATA_W bits: instruction register.
- `Tstep_state` out, 2 bits: current step, T0=0 … T3=3.
- `Z_out` out, 1 bit: zero flag.

## Operation
- RW = $clog2(NREGS).
- IR fields:
  - opcode = IR[DATA_W-1 -: 3]
  - X = IR[DATA_W-4 -: RW]
  - Y = IR[DATA_W-4-RW -: RW]
  - remaining low bits are ignored.
- Opcodes:
  - 000 `mv`: Rx←Ry
  - 001 `mvi`: Rx←DIN
  - 010 `add`: Rx←Rx+Ry
  - 011 `sub`: Rx←Rx−Ry
  - 100 `and`
  - 101 `mvnz`: Rx←Ry only if Z=0
  - 110 `xor`
  - 111 `nop`
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded. `X==Y` is legal: `sub R1,R1` gives 0 and sets Z.
- Step states:
  - **T0**: idle, bus = 0. If Run=1, IR←DIN, go to T1. Otherwise stay.
  - **T1**:
    - `mv`: bus=Ry, Rx←bus, Done, next T0.
    - `mvi`: bus=DIN, Rx←bus, Done, next T0.
    - `mvnz`: bus=Ry; Rx written only if Z=0; Done, next T0.
    - `nop`: bus=0, Done, next T0.
    - ALU ops: bus=Rx, A←bus, next T2.
  - **T2** (ALU ops): bus=Ry, G←A op bus, Z←(A op bus == 0), next T3.
  - **T3** (ALU ops): bus=G, Rx←G, Done, next T0.
- Only ALU ops update Z. `mv`, `mvi`, `mvnz` and `nop` leave Z unchanged.
- Exactly one bus source is active per step. Register, A and G write enables are one-hot or zero.

## Timing
- Reset values: all Rn=0, A=0, G=0, IR=0, Z=1, Tstep=T0, Done=0, BusWires=0.
- Reset is asynchronous. Asserting Resetn mid-instruction aborts the instruction: no partial register write, and the core restarts in T0.
- Latency from the Run-sampling edge to Done high:
  - `mv`, `mvi`, `mvnz`, `nop`: 1 cycle (Done in T1).
  - ALU ops: 3 cycles (Done in T3).
- The destination write lands on the edge that ends the Done cycle.
- Run is ignored outside T0.
- If Run is held high, the next instruction is captured on the edge after the Done cycle (T0 lasts one cycle). There is no back-to-back overlap.
- `mvnz` reads Z as left by the most recently completed ALU op.
- Done is never high in T0 and never high for more than one consecutive cycle per instruction.

## Structure
- Shared package `proc_pkg`:
  - opcode enum `op_e`
  - step enum `tstep_e` (T0..T3)
  - opcode field width constant OPW=3
  - function `rw(nregs)`
- Sub-module `proc_alu`: parametrised in DATA_W. Inputs: op, a, b. Outputs: result, zero. Purely combinational.
- `proc_core_param` holds the step FSM, the control decode, the register file, A, G, IR, Z and the bus mux.

## Test plan
All scenarios use DATA_W=16, NREGS=8.
- **Reset and `mvi`:** Reset, then `mvi R0` with immediate 0x0005 → Done in T1, R0=5, Z stays 1, Tstep returns to 0.
- **`add` timing:** R0=5, R1=3, `add R0,R1` → BusWires shows 5 in T1, 3 in T2 and 8 in T3; Done only in T3; R0=8; Z=0.
- **`sub` wrap and Z:**
  - R2=0, R3=1, `sub R2,R3` → R2=0xFFFF, Z=0.
  - Then `sub R2,R2` → R2=0, Z=1.
- **`mvnz` conditional:**
  - With Z=1, `mvnz R4,R0` → R4 unchanged, Done in T1.
  - After an op that leaves Z=0, repeat `mvnz R4,R0` → R4=R0.
- **Run ignored mid-instruction:** Pulse Run high during T2 of an `and` → no IR change, and the instruction completes normally.
- **Reset mid-instruction:** Assert Resetn=0 in T2 of `add R5,R6` → R5 stays 0 and all outputs return to their reset values immediately.
- **Second configuration:** Re-run the `add` scenario with DATA_W=9, NREGS=4 → same cycle counts, 9-bit wrap (0x1FF+1 = 0, Z=1).
